// File: rtl/mux8_arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way selector arbiter.
package mux8_arb_pkg;

  localparam int NREQ   = 8;
  localparam int SEL_W  = 3;
  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_OWN     = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux8_arbiter_rr_pick8.sv
// Combinational round-robin picker: first set req bit after `last`, wrapping mod 8.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Scan farthest candidate first so the nearest one after `last` overwrites.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = last + SEL_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux8_arbiter.sv
// Round-robin owner sequencer for a shared 8:1 selector with settle delay and
// optional hold limit; all outputs registered.
module mux8_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int SETTLE   = 1,
  parameter int HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  grant,
  output logic [SEL_W-1:0] sel,
  output logic             ce_n,
  output logic             valid,
  output logic             timeout
);

  localparam logic [2:0]        SETTLE_LD = 3'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    return (v == {HOLD_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  arb_state_t        state, state_nx;
  logic [NREQ-1:0]   grant_nx;
  logic [SEL_W-1:0]  sel_nx, last, last_nx, pick;
  logic              ce_n_nx, valid_nx, timeout_nx, found;
  logic [2:0]        scnt, scnt_nx;
  logic [HOLD_W-1:0] hold, hold_nx;

  rr_pick8 u_pick (
    .req   (req),
    .last  (last),
    .found (found),
    .idx   (pick)
  );

  always_comb begin
    state_nx   = state;
    grant_nx   = grant;
    sel_nx     = sel;
    ce_n_nx    = ce_n;
    valid_nx   = valid;
    timeout_nx = 1'b0;
    last_nx    = last;
    scnt_nx    = scnt;
    hold_nx    = hold;
    case (state)
      ST_IDLE, ST_RELEASE: begin
        grant_nx = '0;
        ce_n_nx  = 1'b1;
        valid_nx = 1'b0;
        hold_nx  = '0;
        state_nx = ST_IDLE;
        if (found) begin
          grant_nx = onehot(pick);
          sel_nx   = pick;
          last_nx  = pick;
          ce_n_nx  = 1'b0;
          if (SETTLE > 0) begin
            state_nx = ST_SETTLE;
            scnt_nx  = SETTLE_LD;
          end else begin
            state_nx = ST_OWN;
            valid_nx = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (!req[sel]) begin
          state_nx = ST_RELEASE;
          grant_nx = '0;
          ce_n_nx  = 1'b1;
          valid_nx = 1'b0;
          hold_nx  = '0;
        end else if (scnt == 3'd0) begin
          state_nx = ST_OWN;
          valid_nx = 1'b1;
          hold_nx  = '0;
        end else begin
          scnt_nx = scnt - 3'd1;
        end
      end
      ST_OWN: begin
        // hold counts completed valid cycles, so HOLD_MAX-1 marks the last one
        if (!req[sel] || (HOLD_MAX != 0 && hold == HOLD_LAST)) begin
          state_nx   = ST_RELEASE;
          grant_nx   = '0;
          ce_n_nx    = 1'b1;
          valid_nx   = 1'b0;
          hold_nx    = '0;
          timeout_nx = req[sel];
        end else begin
          hold_nx = sat_inc(hold);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      grant   <= '0;
      sel     <= '0;
      ce_n    <= 1'b1;
      valid   <= 1'b0;
      timeout <= 1'b0;
      last    <= 3'd7;
      scnt    <= '0;
      hold    <= '0;
    end else begin
      state   <= state_nx;
      grant   <= grant_nx;
      sel     <= sel_nx;
      ce_n    <= ce_n_nx;
      valid   <= valid_nx;
      timeout <= timeout_nx;
      last    <= last_nx;
      scnt    <= scnt_nx;
      hold    <= hold_nx;
    end
  end

endmodule

// File: tb/tb_mux8_arbiter.sv
// Directed bench for mux8_arbiter using three parameterisations on shared inputs.
module tb_mux8_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'h00;

  logic [7:0] ga, gb, gc;
  logic [2:0] sa, sb, sc;
  logic       cea, ceb, cec, va, vb, vc, toa, tob, toc;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mux8_arbiter #(.SETTLE(1), .HOLD_MAX(15)) u_a (
    .clk(clk), .reset(reset), .req(req), .grant(ga), .sel(sa),
    .ce_n(cea), .valid(va), .timeout(toa));
  mux8_arbiter #(.SETTLE(0), .HOLD_MAX(4)) u_b (
    .clk(clk), .reset(reset), .req(req), .grant(gb), .sel(sb),
    .ce_n(ceb), .valid(vb), .timeout(tob));
  mux8_arbiter #(.SETTLE(3), .HOLD_MAX(0)) u_c (
    .clk(clk), .reset(reset), .req(req), .grant(gc), .sel(sc),
    .ce_n(cec), .valid(vc), .timeout(toc));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 8'h00;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ga, sa, cea, va, toa} !== {8'h00, 3'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_a got g=%h s=%0d ce_n=%b v=%b to=%b want g=00 s=0 ce_n=1 v=0 to=0",
               ga, sa, cea, va, toa);
    else passes++;
    checks++;
    if ({gb, sb, ceb, vb, tob} !== {8'h00, 3'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_b got g=%h s=%0d ce_n=%b v=%b to=%b want g=00 s=0 ce_n=1 v=0 to=0",
               gb, sb, ceb, vb, tob);
    else passes++;
  endtask

  task automatic test_basic();
    do_reset();
    req = 8'h01;
    step();
    checks++;
    if ({ga, sa, cea, va} !== {8'h01, 3'd0, 1'b0, 1'b0})
      $display("FAIL basic_grant got g=%h s=%0d ce_n=%b v=%b want 01 0 0 0", ga, sa, cea, va);
    else passes++;
    step();
    checks++;
    if ({ga, va} !== {8'h01, 1'b1})
      $display("FAIL basic_valid got g=%h v=%b want 01 1", ga, va);
    else passes++;
    req = 8'h00;
    step();
    checks++;
    if ({ga, cea, va, toa} !== {8'h00, 1'b1, 1'b0, 1'b0})
      $display("FAIL basic_release got g=%h ce_n=%b v=%b to=%b want 00 1 0 0", ga, cea, va, toa);
    else passes++;
    step();
    checks++;
    if ({ga, cea} !== {8'h00, 1'b1})
      $display("FAIL basic_idle got g=%h ce_n=%b want 00 1", ga, cea);
    else passes++;
  endtask

  task automatic test_rotate();
    logic [7:0] eg;
    logic [2:0] es;
    do_reset();
    req = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      es = 3'(n);
      eg = 8'h01 << es;
      for (int c = 0; c < 4; c++) begin
        step();
        checks++;
        if ({gb, sb, ceb, vb, tob} !== {eg, es, 1'b0, 1'b1, 1'b0})
          $display("FAIL rotate_own owner=%0d cyc=%0d got g=%h s=%0d ce_n=%b v=%b to=%b want g=%h s=%0d 0 1 0",
                   n, c, gb, sb, ceb, vb, tob, eg, es);
        else passes++;
      end
      step();
      checks++;
      if ({gb, sb, ceb, vb, tob} !== {8'h00, es, 1'b1, 1'b0, 1'b1})
        $display("FAIL rotate_timeout owner=%0d got g=%h s=%0d ce_n=%b v=%b to=%b want 00 %0d 1 0 1",
                 n, gb, sb, ceb, vb, tob, es);
      else passes++;
    end
    req = 8'h00;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'h20;
    step();
    checks++;
    if ({ga, sa} !== {8'h20, 3'd5})
      $display("FAIL wrap_own5 got g=%h s=%0d want 20 5", ga, sa);
    else passes++;
    step();
    req = 8'h09;
    step();
    checks++;
    if ({ga, cea} !== {8'h00, 1'b1})
      $display("FAIL wrap_release got g=%h ce_n=%b want 00 1", ga, cea);
    else passes++;
    step();
    checks++;
    if ({ga, sa} !== {8'h01, 3'd0})
      $display("FAIL wrap_first got g=%h s=%0d want 01 0", ga, sa);
    else passes++;
    step();
    req = 8'h08;
    step();
    step();
    checks++;
    if ({ga, sa, cea} !== {8'h08, 3'd3, 1'b0})
      $display("FAIL wrap_second got g=%h s=%0d ce_n=%b want 08 3 0", ga, sa, cea);
    else passes++;
    req = 8'h00;
  endtask

  task automatic test_settle();
    int bad;
    do_reset();
    req = 8'h04;
    step();
    checks++;
    if ({gc, sc, cec, vc} !== {8'h04, 3'd2, 1'b0, 1'b0})
      $display("FAIL abort_grant got g=%h s=%0d ce_n=%b v=%b want 04 2 0 0", gc, sc, cec, vc);
    else passes++;
    req = 8'h00;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (vc !== 1'b0 || gc !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0)
      $display("FAIL abort_novalid got %0d bad cycles want 0", bad);
    else passes++;
    req = 8'h04;
    step();
    step();
    step();
    checks++;
    if ({gc, vc} !== {8'h04, 1'b0})
      $display("FAIL settle_wait got g=%h v=%b want 04 0", gc, vc);
    else passes++;
    step();
    checks++;
    if ({gc, vc} !== {8'h04, 1'b1})
      $display("FAIL settle_valid got g=%h v=%b want 04 1", gc, vc);
    else passes++;
    req = 8'h00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'h40;
    step();
    step();
    checks++;
    if ({ga, sa, va} !== {8'h40, 3'd6, 1'b1})
      $display("FAIL midrst_own got g=%h s=%0d v=%b want 40 6 1", ga, sa, va);
    else passes++;
    reset = 1'b1;
    step();
    checks++;
    if ({ga, sa, cea, va, toa} !== {8'h00, 3'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL midrst_vals got g=%h s=%0d ce_n=%b v=%b to=%b want 00 0 1 0 0",
               ga, sa, cea, va, toa);
    else passes++;
    reset = 1'b0;
    req = 8'h41;
    step();
    checks++;
    if ({ga, sa} !== {8'h01, 3'd0})
      $display("FAIL midrst_regrant got g=%h s=%0d want 01 0", ga, sa);
    else passes++;
    req = 8'h00;
  endtask

  task automatic test_unlimited();
    int good;
    do_reset();
    req = 8'h80;
    for (int c = 0; c < 4; c++) step();
    good = 0;
    for (int c = 0; c < 300; c++) begin
      if (gc === 8'h80 && vc === 1'b1 && toc === 1'b0) good++;
      step();
    end
    checks++;
    if (good != 300)
      $display("FAIL unlimited_hold got %0d good cycles want 300", good);
    else passes++;
    req = 8'h00;
    step();
    checks++;
    if ({gc, vc, toc} !== {8'h00, 1'b0, 1'b0})
      $display("FAIL unlimited_release got g=%h v=%b to=%b want 00 0 0", gc, vc, toc);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotate();
    test_wrap();
    test_settle();
    test_reset_mid();
    test_unlimited();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
